// File: rtl/kernel_buffer_sequencer_pkg.sv
// Shared types and constants for the kernel weight buffer sequencer.
// The lane helper gives the first lane that lies outside a complete bank group.
package kernel_seq_pkg;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_W     = 16;
  localparam int unsigned DEF_AW    = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  function automatic int unsigned tail_lane_start(input int unsigned d, input int unsigned trc);
    return (d / (trc + 1)) * (trc + 1);
  endfunction
endpackage

// File: rtl/kernel_buffer_sequencer_if.sv
// Beat stream toward the distributor: D weight lanes plus the {trc, bank_sel} control word.
interface kernel_buffer_sequencer_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 16
);
  localparam int unsigned D = 1 << DEPTH;

  logic                    out_valid;
  logic                    out_ready;
  logic [D-1:0][W-1:0]     out_data;
  logic [2*DEPTH-1:0]      out_ctrl;
  logic                    out_last;

  modport master (output out_valid, output out_data, output out_ctrl, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_ctrl, input  out_last,
                  output out_ready);
endinterface

// File: rtl/kernel_buffer_sequencer_bank.sv
// One kernel weight bank: W x 2**AW flops, synchronous write, combinational read.
// Contents are deliberately left out of reset.
module kernel_bank #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/kernel_buffer_sequencer.sv
// Kernel buffer sequencer: D banks swept per address over bank_sel 0..trc, one beat per slot.
// Optional KERNEL_SEQ_ZERO_TAIL_EN zeroes lanes outside a complete bank group.
module kernel_buffer_sequencer
  import kernel_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [DEPTH-1:0] i_wr_bank,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [W-1:0]     i_wr_data,
  input  logic             i_start,
  input  logic [DEPTH-1:0] i_cfg_trc,
  input  logic [AW-1:0]    i_cfg_last_addr,
  output logic             o_busy,
  output logic             o_done,
  kernel_buffer_sequencer_if.master o_bus
);
  localparam int unsigned D = 1 << DEPTH;

  state_e r_state, w_state_nxt;

  logic [AW-1:0]       r_addr, r_last_addr;
  logic [DEPTH-1:0]    r_sel, r_trc;
  logic                r_valid, r_last, r_done;
  logic [D-1:0][W-1:0] r_data;
  logic [2*DEPTH-1:0]  r_ctrl;

  logic [AW-1:0]       w_cur_addr, w_cur_last;
  logic [DEPTH-1:0]    w_cur_sel, w_cur_trc;
  logic                w_free, w_load, w_final, w_wrap, w_drain_ack;
  logic [D-1:0][W-1:0] w_rd, w_lane;

  for (genvar b = 0; b < D; b++) begin : g_bank
    kernel_bank #(.W(W), .AW(AW)) u_bank (
      .clk     (clk),
      .i_we    (i_wr_en && (i_wr_bank == DEPTH'(b))),
      .i_waddr (i_wr_addr),
      .i_wdata (i_wr_data),
      .i_raddr (w_cur_addr),
      .o_rdata (w_rd[b])
    );
  end

  assign w_free = !r_valid || o_bus.out_ready;

  // In IDLE the first beat is built straight from the cfg inputs so it lands the cycle after start.
  always_comb begin
    w_cur_addr  = r_addr;
    w_cur_sel   = r_sel;
    w_cur_trc   = r_trc;
    w_cur_last  = r_last_addr;
    w_load      = 1'b0;
    w_drain_ack = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        w_cur_addr = '0;
        w_cur_sel  = '0;
        w_cur_trc  = i_cfg_trc;
        w_cur_last = i_cfg_last_addr;
        w_load     = i_start;
      end
      RUN:     w_load      = w_free;
      DRAIN:   w_drain_ack = r_valid && o_bus.out_ready;
      default: w_state_nxt = IDLE;
    endcase
    w_wrap  = (w_cur_sel == w_cur_trc);
    w_final = w_wrap && (w_cur_addr == w_cur_last);
    if (w_load)      w_state_nxt = w_final ? DRAIN : RUN;
    if (w_drain_ack) w_state_nxt = IDLE;
  end

  always_comb begin
    w_lane = w_rd;
`ifdef KERNEL_SEQ_ZERO_TAIL_EN
    for (int unsigned i = 0; i < D; i++) begin
      if (i >= tail_lane_start(D, 32'(w_cur_trc))) w_lane[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_sel       <= '0;
      r_trc       <= '0;
      r_last_addr <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_data      <= '0;
      r_ctrl      <= '0;
    end else begin
      r_done <= w_drain_ack;
      if (w_load) begin
        r_trc       <= w_cur_trc;
        r_last_addr <= w_cur_last;
        r_sel       <= w_wrap ? '0 : w_cur_sel + DEPTH'(1);
        r_addr      <= w_wrap ? w_cur_addr + AW'(1) : w_cur_addr;
        r_valid     <= 1'b1;
        r_last      <= w_final;
        r_data      <= w_lane;
        r_ctrl      <= {w_cur_trc, w_cur_sel};
      end else if (w_drain_ack) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign o_busy          = (r_state != IDLE);
  assign o_done          = r_done;
  assign o_bus.out_valid = r_valid;
  assign o_bus.out_data  = r_data;
  assign o_bus.out_ctrl  = r_ctrl;
  assign o_bus.out_last  = r_last;
endmodule

// File: tb/tb_kernel_buffer_sequencer.sv
// Directed bench for kernel_buffer_sequencer with D=4, W=16, AW=4; bank b addr a preloaded with 16*b+a.
module tb_kernel_buffer_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [3:0] wr_addr;
  logic [15:0] wr_data;
  logic       start;
  logic [1:0] cfg_trc;
  logic [3:0] cfg_last_addr;
  logic       busy, done;

  int n_pass = 0;
  int n_tot  = 0;

  kernel_buffer_sequencer_if #(.DEPTH(2), .W(16)) u_if ();

  kernel_buffer_sequencer #(.DEPTH(2), .W(16), .AW(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_wr_en         (wr_en),
    .i_wr_bank       (wr_bank),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_start         (start),
    .i_cfg_trc       (cfg_trc),
    .i_cfg_last_addr (cfg_last_addr),
    .o_busy          (busy),
    .o_done          (done),
    .o_bus           (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks one beat: valid, ctrl, last and one chosen lane.
  task automatic chk_beat(input string tag, input logic [3:0] ctrl, input logic last,
                          input int lane, input logic [15:0] val);
    chk({tag, "_valid"}, 64'(u_if.out_valid), 64'(1'b1));
    chk({tag, "_ctrl"},  64'(u_if.out_ctrl),  64'(ctrl));
    chk({tag, "_last"},  64'(u_if.out_last),  64'(last));
    chk({tag, "_lane"},  64'(u_if.out_data[lane]), 64'(val));
  endtask

  logic [15:0] exp_l3;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; cfg_trc = '0; cfg_last_addr = '0; u_if.out_ready = 1'b0;
    #1;
    chk("rst_busy",  64'(busy), 64'(1'b0));
    chk("rst_done",  64'(done), 64'(1'b0));
    chk("rst_valid", 64'(u_if.out_valid), 64'(1'b0));
    chk("rst_last",  64'(u_if.out_last), 64'(1'b0));
    chk("rst_data",  64'(u_if.out_data), 64'(0));
    chk("rst_ctrl",  64'(u_if.out_ctrl), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Preload bank b, addr a = 16*b + a
    wr_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        wr_bank = 2'(b); wr_addr = 4'(a); wr_data = 16'(16 * b + a);
        tick();
      end
    end
    wr_en = 1'b0;

    // trc=1, last_addr=1, ready held high: 4 beats then done
    u_if.out_ready = 1'b1;
    start = 1'b1; cfg_trc = 2'd1; cfg_last_addr = 4'd1;
    tick(); start = 1'b0;
    chk_beat("t1b1", 4'h4, 1'b0, 2, 16'h20);
    chk("t1b1_busy", 64'(busy), 64'(1'b1));
    tick(); chk_beat("t1b2", 4'h5, 1'b0, 2, 16'h20);
    tick(); chk_beat("t1b3", 4'h4, 1'b0, 2, 16'h21);
    chk("t1b3_l0", 64'(u_if.out_data[0]), 64'(16'h01));
    tick(); chk_beat("t1b4", 4'h5, 1'b1, 2, 16'h21);
    chk("t1b4_l3", 64'(u_if.out_data[3]), 64'(16'h31));
    chk("t1b4_done", 64'(done), 64'(1'b0));
    tick();
    chk("t1_valid_end", 64'(u_if.out_valid), 64'(1'b0));
    chk("t1_done", 64'(done), 64'(1'b1));
    chk("t1_busy_end", 64'(busy), 64'(1'b0));
    tick();
    chk("t1_done_pulse", 64'(done), 64'(1'b0));

    // trc=3, last_addr=0, ready toggling: beats held during stalls
    start = 1'b1; cfg_trc = 2'd3; cfg_last_addr = 4'd0;
    tick(); start = 1'b0;
    chk_beat("t2s0", 4'hC, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b0; tick(); chk_beat("t2s0h", 4'hC, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b1; tick(); chk_beat("t2s1", 4'hD, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b0; tick(); chk_beat("t2s1h", 4'hD, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b1; tick(); chk_beat("t2s2", 4'hE, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b0; tick(); chk_beat("t2s2h", 4'hE, 1'b0, 1, 16'h10);
    u_if.out_ready = 1'b1; tick(); chk_beat("t2s3", 4'hF, 1'b1, 1, 16'h10);
    u_if.out_ready = 1'b0; tick(); chk_beat("t2s3h", 4'hF, 1'b1, 1, 16'h10);
    chk("t2_hold_busy", 64'(busy), 64'(1'b1));
    chk("t2_hold_done", 64'(done), 64'(1'b0));
    u_if.out_ready = 1'b1; tick();
    chk("t2_valid_end", 64'(u_if.out_valid), 64'(1'b0));
    chk("t2_done", 64'(done), 64'(1'b1));
    tick();

    // Write bank0 addr0 in the same cycle as the beat loads: old value seen
    start = 1'b1; cfg_trc = 2'd0; cfg_last_addr = 4'd0;
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 4'd0; wr_data = 16'hBEEF;
    tick(); start = 1'b0; wr_en = 1'b0;
    chk_beat("t3old", 4'h0, 1'b1, 0, 16'h0000);
    tick(); chk("t3_done", 64'(done), 64'(1'b1));
    start = 1'b1;
    tick(); start = 1'b0;
    chk_beat("t3new", 4'h0, 1'b1, 0, 16'hBEEF);
    tick(); tick();

    // Start while busy is ignored
    start = 1'b1; cfg_trc = 2'd1; cfg_last_addr = 4'd0;
    tick();
    chk_beat("t4b1", 4'h4, 1'b0, 3, 16'h30);
    cfg_trc = 2'd3; cfg_last_addr = 4'd5;
    tick(); start = 1'b0;
    chk_beat("t4b2", 4'h5, 1'b1, 3, 16'h30);
    tick();
    chk("t4_valid_end", 64'(u_if.out_valid), 64'(1'b0));
    chk("t4_done", 64'(done), 64'(1'b1));
    tick();
    chk("t4_no_extra", 64'(u_if.out_valid), 64'(1'b0));
    chk("t4_idle", 64'(busy), 64'(1'b0));

    // Reset mid-sweep aborts asynchronously; no done afterwards
    start = 1'b1; cfg_trc = 2'd3; cfg_last_addr = 4'd3;
    tick(); start = 1'b0;
    tick(); tick();
    chk_beat("t5mid", 4'hE, 1'b0, 2, 16'h20);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(u_if.out_valid), 64'(1'b0));
    chk("t5_data",  64'(u_if.out_data), 64'(0));
    chk("t5_ctrl",  64'(u_if.out_ctrl), 64'(0));
    chk("t5_busy",  64'(busy), 64'(1'b0));
    chk("t5_last",  64'(u_if.out_last), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", 64'(done), 64'(1'b0));
    chk("t5_idle_valid", 64'(u_if.out_valid), 64'(1'b0));
    start = 1'b1; cfg_trc = 2'd1; cfg_last_addr = 4'd0;
    tick(); start = 1'b0;
    chk_beat("t5r1", 4'h4, 1'b0, 1, 16'h10);
    tick(); chk_beat("t5r2", 4'h5, 1'b1, 1, 16'h10);
    tick(); chk("t5r_done", 64'(done), 64'(1'b1));
    tick();

    // trc=2: lane 3 lies outside the only complete group of 3 banks
`ifdef KERNEL_SEQ_ZERO_TAIL_EN
    exp_l3 = 16'h0000;
`else
    exp_l3 = 16'h0030;
`endif
    start = 1'b1; cfg_trc = 2'd2; cfg_last_addr = 4'd0;
    tick(); start = 1'b0;
    chk_beat("t6b1", 4'h8, 1'b0, 3, exp_l3);
    chk("t6b1_l2", 64'(u_if.out_data[2]), 64'(16'h20));
    tick(); chk_beat("t6b2", 4'h9, 1'b0, 3, exp_l3);
    tick(); chk_beat("t6b3", 4'hA, 1'b1, 3, exp_l3);
    tick(); chk("t6_done", 64'(done), 64'(1'b1));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
